// File: rtl/crc_guts_core.sv
// Bit-serial CRC LFSR shared by the link transmitter (generator) and receiver (checker).
// Latency: a bit sampled on b_in is reflected on o_b_out/o_zero one cycle after that edge.
// Backpressure: none; i_gate low holds the register, so any number of idle cycles is allowed.
module crc_guts_core #(
    parameter int unsigned          WIDTH = 16,
    parameter logic [WIDTH-1:0]     POLY  = 16'h1021,
    parameter logic [WIDTH-1:0]     INIT  = 16'hFFFF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_gate,
    input  logic i_clear,
    input  logic i_b_in,
    output logic o_b_out,
    output logic o_zero
);

    // CRC register; taps come only from POLY, so the same code serves every WIDTH.
    logic [WIDTH-1:0] r_sr;

    // Feedback is the incoming bit folded with the bit about to leave the register.
    // During CRC append the generator feeds o_b_out back, which forces w_fb to 0
    // and turns the LFSR into a plain shifter that drains to all-zeros.
    logic             w_fb;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_sr_nxt;

    assign w_fb    = i_b_in ^ r_sr[WIDTH-1];
    assign w_shift = {r_sr[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : {WIDTH{1'b0}});

    // Next-state select: clear beats gate (its b_in bit is dropped), otherwise shift or hold.
    always_comb begin
        w_sr_nxt = r_sr;
        if (i_clear) begin
            w_sr_nxt = INIT;
        end else if (i_gate) begin
            w_sr_nxt = w_shift;
        end
    end

    // State update; reset loads INIT immediately so a frame in flight is abandoned.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= INIT;
        end else begin
            r_sr <= w_sr_nxt;
        end
    end

    // Outputs depend on the register alone, never on this cycle's inputs.
    assign o_b_out = r_sr[WIDTH-1];
    assign o_zero  = (r_sr == {WIDTH{1'b0}});

endmodule

// File: tb/tb_crc_guts_core.sv
// Directed bench for crc_guts_core: generator/checker pair at default parameters
// plus a third instance with INIT=0. Expected values are pushed into a scoreboard
// queue when stimulus is applied and popped when the DUT result is sampled.
module tb_crc_guts_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic g_gate = 1'b0, g_clear = 1'b0, g_b_in = 1'b0, g_b_out, g_zero;
    logic c_gate = 1'b0, c_clear = 1'b0, c_b_in = 1'b0, c_b_out, c_zero;
    logic z_gate = 1'b0, z_clear = 1'b0, z_b_in = 1'b0, z_b_out, z_zero;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_g, m_c, m_z;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    crc_guts_core u_gen (
        .i_clk(clk), .i_rst_n(rst_n), .i_gate(g_gate), .i_clear(g_clear),
        .i_b_in(g_b_in), .o_b_out(g_b_out), .o_zero(g_zero)
    );

    crc_guts_core u_chk (
        .i_clk(clk), .i_rst_n(rst_n), .i_gate(c_gate), .i_clear(c_clear),
        .i_b_in(c_b_in), .o_b_out(c_b_out), .o_zero(c_zero)
    );

    crc_guts_core #(.WIDTH(16), .POLY(16'h1021), .INIT(16'h0000)) u_z (
        .i_clk(clk), .i_rst_n(rst_n), .i_gate(z_gate), .i_clear(z_clear),
        .i_b_in(z_b_in), .o_b_out(z_b_out), .o_zero(z_zero)
    );

    // Reference CCITT step taken straight from the shift equation.
    function automatic logic [15:0] nxt(input logic [15:0] s, input logic clr,
                                        input logic gt, input logic b,
                                        input logic [15:0] init);
        logic fb;
        if (clr) return init;
        if (!gt) return s;
        fb = b ^ s[15];
        return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    // One clock: advance the models from the inputs as driven, then sample after the edge.
    task automatic cyc();
        logic [15:0] ng, nc, nz;
        ng = nxt(m_g, g_clear, g_gate, g_b_in, 16'hFFFF);
        nc = nxt(m_c, c_clear, c_gate, c_b_in, 16'hFFFF);
        nz = nxt(m_z, z_clear, z_gate, z_b_in, 16'h0000);
        @(posedge clk);
        #1;
        m_g = ng;
        m_c = nc;
        m_z = nz;
    endtask

    // Payload then 16 looped-back CRC bits; checker sees the same stream, optionally with one bit flipped.
    task automatic run_frame(input logic [31:0] payload, input bit do_clear,
                             input int flip_idx, input bit exp_chk_zero);
        logic gb;
        if (do_clear) begin
            g_clear = 1'b1; c_clear = 1'b1;
            cyc();
            g_clear = 1'b0; c_clear = 1'b0;
        end
        g_gate = 1'b1; c_gate = 1'b1;
        for (int i = 31; i >= 0; i--) begin
            g_b_in = payload[i];
            c_b_in = payload[i] ^ (i == flip_idx);
            cyc();
        end
        push("payload_sr", {16'h0, m_g});
        check({16'h0, u_gen.r_sr});
        for (int k = 0; k < 16; k++) begin
            gb     = g_b_out;
            g_b_in = gb;
            c_b_in = gb;
            cyc();
        end
        g_gate = 1'b0; c_gate = 1'b0;
        push("gen_zero", 32'd1);
        check({31'd0, g_zero});
        push("chk_zero", {31'd0, exp_chk_zero});
        check({31'd0, c_zero});
        push("chk_sr_model", {16'h0, m_c});
        check({16'h0, u_chk.r_sr});
    endtask

    initial begin
        logic [15:0] held;
        logic        held_b, held_z;
        logic [71:0] kat;
        logic [31:0] pl;

        m_g = 16'hFFFF; m_c = 16'hFFFF; m_z = 16'h0000;
        #22;
        rst_n = 1'b1;
        cyc();

        // Reset state
        push("rst_sr", 32'hFFFF);   check({16'h0, u_gen.r_sr});
        push("rst_b_out", 32'd1);   check({31'd0, g_b_out});
        push("rst_zero", 32'd0);    check({31'd0, g_zero});
        push("rst_z_zero", 32'd1);  check({31'd0, z_zero});

        // Clear with gate and b_in high: clear wins, bit discarded
        g_clear = 1'b1; g_gate = 1'b1; g_b_in = 1'b1;
        cyc();
        g_clear = 1'b0;
        push("clear_sr", 32'hFFFF); check({16'h0, u_gen.r_sr});

        // Single step from FFFF with b_in=0
        g_b_in = 1'b0;
        cyc();
        g_gate = 1'b0;
        push("step0_sr", 32'hEFDF); check({16'h0, u_gen.r_sr});
        push("step0_b_out", 32'd1); check({31'd0, g_b_out});

        // Single step from INIT=0 with b_in=1
        z_gate = 1'b1; z_b_in = 1'b1;
        cyc();
        z_gate = 1'b0;
        push("z_step_sr", 32'h1021); check({16'h0, u_z.r_sr});
        push("z_step_zero", 32'd0);  check({31'd0, z_zero});

        // Gate low: register and outputs hold whatever b_in does
        held = u_gen.r_sr; held_b = g_b_out; held_z = g_zero;
        for (int i = 0; i < 5; i++) begin
            g_b_in = 1'($urandom_range(1));
            cyc();
            push("hold_sr", {16'h0, m_g});      check({16'h0, u_gen.r_sr});
            push("hold_b_out", {31'd0, held_b}); check({31'd0, g_b_out});
            push("hold_zero", {31'd0, held_z});  check({31'd0, g_zero});
        end
        push("hold_model", {16'h0, held}); check({16'h0, m_g});

        // Known answer: CCITT-FALSE over ASCII "123456789" is 16'h29B1
        kat = "123456789";
        g_clear = 1'b1; cyc(); g_clear = 1'b0;
        g_gate = 1'b1;
        for (int i = 71; i >= 0; i--) begin
            g_b_in = kat[i];
            cyc();
        end
        g_gate = 1'b0;
        push("kat_sr", 32'h29B1); check({16'h0, u_gen.r_sr});

        // Good frames with distinct payloads, including an idle gap mid-frame-free
        for (int f = 0; f < 4; f++) begin
            pl = $urandom() ^ (32'h1 << f);
            run_frame(pl, 1'b1, -1, 1'b1);
            cyc();
            cyc();
        end
        run_frame(32'h0000_0000, 1'b1, -1, 1'b1);

        // Single payload bit flipped on the checker's input only
        run_frame(32'hA5C3_0F96, 1'b1, 7, 1'b0);
        run_frame(32'h1234_5678, 1'b1, 31, 1'b0);

        // Reset mid-frame: register reloads INIT with no clock edge
        g_clear = 1'b1; c_clear = 1'b1; cyc(); g_clear = 1'b0; c_clear = 1'b0;
        g_gate = 1'b1; c_gate = 1'b1;
        pl = 32'hDEAD_BEEF;
        for (int i = 31; i >= 22; i--) begin
            g_b_in = pl[i]; c_b_in = pl[i];
            cyc();
        end
        g_gate = 1'b0; c_gate = 1'b0;
        rst_n = 1'b0;
        #2;
        push("mid_rst_sr", 32'hFFFF);  check({16'h0, u_gen.r_sr});
        push("mid_rst_b_out", 32'd1);  check({31'd0, g_b_out});
        push("mid_rst_chk_sr", 32'hFFFF); check({16'h0, u_chk.r_sr});
        m_g = 16'hFFFF; m_c = 16'hFFFF; m_z = 16'h0000;
        #1;
        rst_n = 1'b1;
        run_frame(32'hCAFE_F00D, 1'b0, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc_guts_core.md
# crc_guts_core

Bit-serial CRC engine (LFSR) used on both ends of a serial link. The transmitter shifts its payload through the engine, then loops `b_out` back to `b_in` to append the CRC. The receiver shifts the same bit stream, payload plus CRC, through an identical engine and checks `zero`. Matching state on both sides is the whole mechanism: generator and checker are the same block.

## Interface
- `WIDTH`, default 16: CRC register width, in bits.
- `POLY`, default 16'h1021: generator polynomial with the implicit x^WIDTH term omitted (CRC-16-CCITT).
- `INIT`, default 16'hFFFF: value loaded into the register by reset and by `clear`.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low. Forces the register to `INIT`.
- `gate`, input, 1: shift enable. While low, the register holds.
- `clear`, input, 1: synchronous reload of `INIT`, one cycle wide.
- `b_in`, input, 1: serial data bit for this cycle.
- `b_out`, output, 1: register MSB, `sr[WIDTH-1]`.
- `zero`, output, 1: high when the whole register equals 0.

## Operation
- Internal state is `sr[WIDTH-1:0]`.
- Feedback bit: `fb = b_in XOR sr[WIDTH-1]`.
- Shift step: `sr <= {sr[WIDTH-2:0],1'b0} XOR (fb ? POLY : 0)`.
- Priority on each rising edge:
  1. `rst_n` low (asynchronous).
  2. `clear`: `sr <= INIT`. This ignores `gate` and `b_in`, and the `b_in` bit on that cycle is discarded.
  3. `gate` high: one shift step.
  4. Otherwise: hold.
- CRC append: the generator drives `b_in = b_out` for WIDTH gated cycles.
  - `fb` is 0 on each of those cycles, so the register shifts its contents out MSB first and ends at 0.
  - A checker fed the same bits follows the same sequence and also ends at 0, so `zero` = 1 means the frame is good.
- `zero` is only meaningful after the full WIDTH CRC bits have been shifted. Mid-frame it is just the register compare.
- Parameter rules:
  - Supported range is `WIDTH` 8 to 32.
  - `POLY` and `INIT` are truncated to `WIDTH` bits.
  - `POLY` bit 0 is expected to be 1. This is not checked.
  - The implementation must be generic in `WIDTH`: no hard-coded taps.

## Timing
- Reset values: `sr = INIT`. With the defaults, `b_out` = 1 and `zero` = 0.
- `b_out` and `zero` are combinational from `sr` only.
  - No combinational path from `b_in`, `gate` or `clear` to either output.
  - Both change only after a clock edge, or on reset assertion.
- Latency: the effect of a bit on `b_in` is visible on `b_out`/`zero` one cycle after the edge that samples it.
- When `clear` and `gate` are both high, `clear` wins and the register reads `INIT` the next cycle.
- `gate` low for any number of cycles inserts idle cycles without corrupting the CRC. Frames may have arbitrary gaps.
- `rst_n` asserted mid-frame loads `INIT` immediately; the frame is lost. Deassertion is synchronized externally; the block needs no recovery cycle.
- One bit per clock maximum. No handshake beyond `gate`.

## Test plan
- Reset, default parameters:
  - Release `rst_n` -> `sr`=16'hFFFF, `b_out`=1, `zero`=0.
  - Then `clear`=1 for one cycle with `b_in`=1 -> `sr` still 16'hFFFF (bit discarded).
- Single step from INIT:
  - After `clear`, one gated cycle with `b_in`=0 -> `sr`=16'hEFDF.
  - From `INIT`=0 (parameter override), one gated cycle with `b_in`=1 -> `sr`=16'h1021.
- Gate hold: `gate`=0 for 5 cycles with random `b_in` -> `sr` unchanged, `b_out`/`zero` stable.
- Loopback frame:
  - `clear`, shift 32 random payload bits MSB first with `gate`=1.
  - Generator then self-feeds `b_out` for 16 cycles while a second instance receives the same stream.
  - Required: both instances reach `zero`=1 after exactly 16 CRC bits. Repeat for at least 4 frames with distinct payloads; no failures.
- Error detection: as in the loopback frame, but flip one payload bit on the checker's input only -> checker `zero`=0 at the end of the frame.
- Reset mid-frame: assert `rst_n` low after 10 payload bits -> `sr`=`INIT` without waiting for a clock edge. A following complete frame checks good.
